// File: rtl/eth_tx_arb_pkg.sv
// Shared constants, state encoding and helpers for the eth_mac transmit arbiter.
package eth_tx_arb_pkg;

  // Largest frame the MAC accepts, FCS excluded.
  localparam int MAX_FRAME_LEN = 1514;
  // Width of the per-frame byte counter (covers MAX_FRAME_LEN).
  localparam int LEN_W         = 11;
  // Width of the truncation / stray statistics counters.
  localparam int CNT_W         = 16;
  // Grant / round-robin pointer width used when N needs no encoding bits.
  localparam int RR_W_DEF      = 1;
  // Widest per-cycle stray increment (up to 4 sources at once).
  localparam int INC_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;

  // Saturating add for the statistics counters; they stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, searched cyclically.
module eth_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  // Walk from the farthest rotated position to the nearest so the
  // nearest requester (closest to ptr) is the last, winning, assignment.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-level round-robin arbiter in front of the eth_mac transmit port.
// A grant is locked from sof to eof; over-long frames are cut at MAX_LEN with
// eof+err and their tail is flushed; bytes outside a frame are dropped.
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int MAX_LEN = MAX_FRAME_LEN
) (
  input  logic             clk_mac,
  input  logic             rst_n,
  input  logic [N-1:0]     s_vld,
  input  logic [8*N-1:0]   s_dat,
  input  logic [N-1:0]     s_sof,
  input  logic [N-1:0]     s_eof,
  input  logic [N-1:0]     s_err,
  output logic [N-1:0]     s_ack,
  output logic             m_vld,
  output logic [7:0]       m_dat,
  output logic             m_sof,
  output logic             m_eof,
  output logic             m_err,
  input  logic             m_ack,
  output logic [CNT_W-1:0] trunc_cnt,
  output logic [CNT_W-1:0] stray_cnt
);

  localparam int                GW       = (N > 1) ? $clog2(N) : RR_W_DEF;
  localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(MAX_LEN - 1);
  localparam logic [GW-1:0]     LAST_SRC = GW'(N - 1);

  arb_state_t        state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;
  logic [LEN_W-1:0]  byte_cnt;

  logic [N-1:0][7:0] dat_v;
  logic [N-1:0]      cand;
  logic [N-1:0]      stray_v;
  logic              pick_any;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     next_ptr;
  logic              g_vld, g_sof, g_eof, g_err;
  logic [7:0]        g_dat;
  logic              is_idle, is_busy, is_flush;
  logic              trunc_now;
  logic              byte_fire;
  logic [INC_W-1:0]  stray_inc;

  assign dat_v    = s_dat;
  assign cand     = s_vld & s_sof;

  assign is_idle  = (state == ST_IDLE);
  assign is_busy  = (state == ST_BUSY);
  assign is_flush = (state == ST_FLUSH);

  // Granted source's lane
  assign g_vld = s_vld[grant];
  assign g_sof = s_sof[grant];
  assign g_eof = s_eof[grant];
  assign g_err = s_err[grant];
  assign g_dat = dat_v[grant];

  assign next_ptr = (grant == LAST_SRC) ? '0 : grant + GW'(1);

  eth_rr_pick #(
    .N  (N),
    .PW (GW)
  ) u_pick (
    .req (cand),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Stray bytes (valid without sof while idle) are swallowed per lane.
  // Gated by rst_n so s_ack is quiet the instant reset asserts.
  for (genvar i = 0; i < N; i++) begin : g_stray
    assign stray_v[i] = is_idle & rst_n & s_vld[i] & ~s_sof[i];
  end

  // Last permitted byte of an unterminated frame: force it to end in error.
  assign trunc_now = is_busy & (byte_cnt == LAST_IDX) & ~g_eof;

  // MAC-side outputs are a straight combinational mux while a frame is locked.
  assign m_vld = is_busy & g_vld;
  assign m_dat = is_busy ? g_dat : 8'h00;
  assign m_sof = is_busy & g_sof;
  assign m_eof = is_busy & (g_eof | trunc_now);
  assign m_err = is_busy & (g_err | trunc_now);

  assign byte_fire = m_vld & m_ack;

  // Source acks: strays while idle, MAC ack while busy, self-ack while flushing.
  always_comb begin
    s_ack = stray_v;
    if (is_busy)  s_ack[grant] = m_ack;
    if (is_flush) s_ack[grant] = g_vld;
  end

  // Bytes dropped this cycle: every idle stray, or the flushed tail byte.
  always_comb begin
    stray_inc = '0;
    for (int i = 0; i < N; i++) stray_inc = stray_inc + INC_W'(stray_v[i]);
    if (is_flush && g_vld) stray_inc = INC_W'(1);
  end

  // Arbitration FSM with frame length tracking and statistics.
  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      trunc_cnt <= '0;
      stray_cnt <= '0;
    end else begin
      if (stray_inc != '0) stray_cnt <= sat_add(stray_cnt, stray_inc);
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            byte_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (byte_fire) begin
            if (m_eof) begin
              byte_cnt <= '0;
              if (trunc_now) begin
                trunc_cnt <= sat_add(trunc_cnt, INC_W'(1));
                state     <= ST_FLUSH;
              end else begin
                rr_ptr <= next_ptr;
                state  <= ST_IDLE;
              end
            end else begin
              byte_cnt <= byte_cnt + LEN_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (g_vld && g_eof) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: queue-driven sources, a frame-level
// reference model checked every cycle, and directed literal expectations.
module tb_eth_tx_arb;

  localparam int N       = 2;
  localparam int MAX_LEN = 1514;

  logic           clk_mac = 1'b0;
  logic           rst_n   = 1'b1;
  logic [N-1:0]   s_vld, s_sof, s_eof, s_err, s_ack;
  logic [8*N-1:0] s_dat;
  logic           m_vld, m_sof, m_eof, m_err, m_ack;
  logic [7:0]     m_dat;
  logic [15:0]    trunc_cnt, stray_cnt;

  always #5 clk_mac = ~clk_mac;

  eth_tx_arb #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk_mac   (clk_mac),
    .rst_n     (rst_n),
    .s_vld     (s_vld),
    .s_dat     (s_dat),
    .s_sof     (s_sof),
    .s_eof     (s_eof),
    .s_err     (s_err),
    .s_ack     (s_ack),
    .m_vld     (m_vld),
    .m_dat     (m_dat),
    .m_sof     (m_sof),
    .m_eof     (m_eof),
    .m_err     (m_err),
    .m_ack     (m_ack),
    .trunc_cnt (trunc_cnt),
    .stray_cnt (stray_cnt)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
    logic       err;
  } sbyte_t;

  sbyte_t srcq [N][$];
  bit     held [N];

  int checks   = 0;
  int failures = 0;
  int ack_mode = 0;
  bit gaps     = 1'b0;
  int cyc      = 0;

  // Reference model: who owns the link, whether the owner's tail is being
  // discarded, bytes delivered in the current frame, next preferred source.
  int mo_owner = -1;
  bit mo_flush = 1'b0;
  int mo_len   = 0;
  int mo_ptr   = 0;
  int mo_trunc = 0;
  int mo_stray = 0;
  int fl_owner [$];
  int fl_len   [$];
  bit fl_trunc [$];

  // Observations of the DUT for the directed literal expectations.
  int ack_seen [N];
  int mvld_seen;
  int bytes_out;
  int dut_first;
  int sof_cyc [$];
  int eof_cyc [$];

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int s, input int len, input int base, input int err_pct);
    sbyte_t b;
    for (int k = 0; k < len; k++) begin
      b.dat = 8'((base + k * 7) & 255);
      b.sof = (k == 0);
      b.eof = (k == len - 1);
      b.err = (int'($urandom_range(0, 99)) < err_pct);
      srcq[s].push_back(b);
    end
  endtask

  task automatic push_stray(input int s, input int n);
    sbyte_t b;
    for (int k = 0; k < n; k++) begin
      b.dat = 8'($urandom);
      b.sof = 1'b0;
      b.eof = 1'b0;
      b.err = 1'b0;
      srcq[s].push_back(b);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) ack_seen[i] = 0;
    mvld_seen = 0;
    bytes_out = 0;
    dut_first = -1;
    sof_cyc.delete();
    eof_cyc.delete();
    fl_owner.delete();
    fl_len.delete();
    fl_trunc.delete();
  endtask

  task automatic drive_idle();
    s_vld = '0; s_sof = '0; s_eof = '0; s_err = '0; s_dat = '0;
  endtask

  // One clock: drive sources, check at mid-cycle, advance model and sources.
  task automatic step();
    logic [N-1:0] ea;
    logic         ev;
    logic [10:0]  eb;
    bit           tr;
    int           o;
    sbyte_t       sb;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && (held[i] || !gaps || $urandom_range(0, 3) != 0)) begin
        s_vld[i]       = 1'b1;
        s_dat[8*i +: 8] = srcq[i][0].dat;
        s_sof[i]       = srcq[i][0].sof;
        s_eof[i]       = srcq[i][0].eof;
        s_err[i]       = srcq[i][0].err;
      end else begin
        s_vld[i]       = 1'b0;
        s_dat[8*i +: 8] = 8'h00;
        s_sof[i]       = 1'b0;
        s_eof[i]       = 1'b0;
        s_err[i]       = 1'b0;
      end
    end
    case (ack_mode)
      0:       m_ack = 1'b1;
      1:       m_ack = ((cyc % 8) == 7);
      default: m_ack = 1'($urandom_range(0, 1));
    endcase
    #4;
    ea = '0; ev = 1'b0; eb = '0; tr = 1'b0; o = mo_owner;
    if (o < 0) begin
      for (int i = 0; i < N; i++) ea[i] = s_vld[i] & ~s_sof[i];
    end else if (!mo_flush) begin
      tr    = (mo_len == MAX_LEN - 1) && !s_eof[o];
      ev    = s_vld[o];
      eb    = {s_dat[8*o +: 8], s_sof[o], s_eof[o] | tr, s_err[o] | tr};
      ea[o] = m_ack;
    end else begin
      ea[o] = s_vld[o];
    end
    chk("s_ack", 32'(s_ack), 32'(ea));
    chk("m_vld", 32'(m_vld), 32'(ev));
    if (ev) chk("m_byte", 32'({m_dat, m_sof, m_eof, m_err}), 32'(eb));
    chk("trunc_cnt", 32'(trunc_cnt), 32'(mo_trunc));
    chk("stray_cnt", 32'(stray_cnt), 32'(mo_stray));
    for (int i = 0; i < N; i++) if (s_vld[i] && s_ack[i]) ack_seen[i]++;
    if (m_vld) mvld_seen++;
    if (m_vld && dut_first < 0) dut_first = cyc;
    if (m_vld && m_ack) bytes_out++;
    if (m_vld && m_ack && m_sof) sof_cyc.push_back(cyc);
    if (m_vld && m_ack && m_eof) eof_cyc.push_back(cyc);
    // Model update at the coming edge.
    if (o < 0) begin
      mo_stray = sat(mo_stray + $countones(ea));
      for (int k = N - 1; k >= 0; k--) begin
        int j = (mo_ptr + k) % N;
        if (s_vld[j] && s_sof[j]) mo_owner = j;
      end
      mo_len = 0;
    end else if (!mo_flush) begin
      if (ev && m_ack) begin
        mo_len++;
        if (eb[1]) begin
          fl_owner.push_back(o);
          fl_len.push_back(mo_len);
          fl_trunc.push_back(tr);
          if (tr) begin
            mo_trunc = sat(mo_trunc + 1);
            mo_flush = 1'b1;
          end else begin
            mo_ptr   = (o + 1) % N;
            mo_owner = -1;
          end
        end
      end
    end else if (s_vld[o]) begin
      mo_stray = sat(mo_stray + 1);
      if (s_eof[o]) begin
        mo_flush = 1'b0;
        mo_owner = -1;
        mo_ptr   = (o + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_vld[i] && ea[i]) begin
        sb      = srcq[i].pop_front();
        held[i] = 1'b0;
      end else begin
        held[i] = s_vld[i];
      end
    end
    @(posedge clk_mac);
    #1;
    cyc++;
  endtask

  function automatic bit work_left();
    bit w = (mo_owner >= 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) w = 1'b1;
    return w;
  endfunction

  task automatic run_idle(input int max_cyc, input string name);
    int n = 0;
    while (work_left() && n < max_cyc) begin
      step();
      n++;
    end
    chk({name, "_done"}, 32'(n < max_cyc), 32'd1);
  endtask

  // Assert reset (possibly mid-frame), check outputs drop at once, release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", 32'({m_vld, m_sof, m_eof, m_err, m_dat, s_ack}), 32'd0);
    chk("rst_counters", {trunc_cnt, stray_cnt}, 32'd0);
    drive_idle();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      held[i] = 1'b0;
    end
    repeat (2) @(posedge clk_mac);
    #1;
    rst_n    = 1'b1;
    mo_owner = -1;
    mo_flush = 1'b0;
    mo_len   = 0;
    mo_ptr   = 0;
    mo_trunc = 0;
    mo_stray = 0;
    clear_obs();
  endtask

  initial begin
    int t0;
    int nfr;
    drive_idle();
    m_ack = 1'b0;
    #2;
    do_reset();

    // Simultaneous requests from rr_ptr=0: frame 0 whole, one idle, frame 1.
    push_frame(0, 10, 16, 0);
    push_frame(1, 12, 128, 0);
    run_idle(200, "t1");
    chk("t1_frames", 32'(fl_owner.size()), 32'd2);
    chk("t1_first_owner", 32'(fl_owner[0]), 32'd0);
    chk("t1_second_owner", 32'(fl_owner[1]), 32'd1);
    chk("t1_gap", 32'(sof_cyc[1] - eof_cyc[0]), 32'd2);
    chk("t1_acks0", 32'(ack_seen[0]), 32'd10);
    chk("t1_acks1", 32'(ack_seen[1]), 32'd12);

    // Single 64-byte frame: latency, sof/eof placement, pointer moves to 1.
    do_reset();
    push_frame(0, 64, 3, 0);
    t0 = cyc;
    run_idle(200, "t2");
    chk("t2_latency", 32'(dut_first - t0), 32'd1);
    chk("t2_acks", 32'(ack_seen[0]), 32'd64);
    chk("t2_bytes", 32'(bytes_out), 32'd64);
    chk("t2_sofs", 32'(sof_cyc.size()), 32'd1);
    chk("t2_eofs", 32'(eof_cyc.size()), 32'd1);
    chk("t2_eof_pos", 32'(eof_cyc[0] - sof_cyc[0]), 32'd63);
    chk("t2_model_ptr", 32'(mo_ptr), 32'd1);
    push_frame(0, 3, 50, 0);
    push_frame(1, 3, 90, 0);
    run_idle(100, "t2b");
    chk("t2_next_owner", 32'(fl_owner[1]), 32'd1);

    // MAC throttled to one ack in eight.
    clear_obs();
    ack_mode = 1;
    push_frame(1, 20, 64, 10);
    run_idle(400, "t3");
    chk("t3_acks", 32'(ack_seen[1]), 32'd20);
    chk("t3_bytes", 32'(bytes_out), 32'd20);
    ack_mode = 0;

    // 1600-byte frame truncated at 1514, 86 bytes flushed.
    do_reset();
    push_frame(0, 1600, 0, 0);
    run_idle(2000, "t4");
    chk("t4_trunc_cnt", 32'(trunc_cnt), 32'd1);
    chk("t4_stray_cnt", 32'(stray_cnt), 32'd86);
    chk("t4_len", 32'(fl_len[0]), 32'd1514);
    chk("t4_trunc_flag", 32'(fl_trunc[0]), 32'd1);
    chk("t4_bytes", 32'(bytes_out), 32'd1514);
    chk("t4_acks", 32'(ack_seen[0]), 32'd1600);

    // Three stray bytes on source 1 while idle.
    clear_obs();
    push_stray(1, 3);
    run_idle(20, "t5");
    chk("t5_stray_cnt", 32'(stray_cnt), 32'd89);
    chk("t5_acks", 32'(ack_seen[1]), 32'd3);
    chk("t5_no_mvld", 32'(mvld_seen), 32'd0);

    // Reset mid-frame; afterwards arbitration restarts from source 0.
    do_reset();
    push_frame(0, 5, 7, 0);
    run_idle(50, "t6a");
    chk("t6_model_ptr", 32'(mo_ptr), 32'd1);
    push_frame(1, 30, 9, 0);
    repeat (10) step();
    chk("t6_midframe", 32'(mvld_seen > 0), 32'd1);
    do_reset();
    push_frame(1, 4, 11, 0);
    push_frame(0, 4, 13, 0);
    run_idle(50, "t6b");
    chk("t6_owner_after_reset", 32'(fl_owner[0]), 32'd0);

    // Continuous requests from both sources alternate strictly.
    clear_obs();
    for (int r = 0; r < 3; r++) begin
      push_frame(0, 8, r * 16, 0);
      push_frame(1, 8, r * 16 + 100, 0);
    end
    run_idle(200, "t7");
    chk("t7_frames", 32'(fl_owner.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk("t7_order", 32'(fl_owner[k]), 32'(k % 2));

    // Randomized traffic: gaps, strays, error flags, random MAC back-pressure.
    clear_obs();
    ack_mode = 2;
    gaps     = 1'b1;
    nfr      = 0;
    for (int f = 0; f < 40; f++) begin
      int s = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 4) == 0) push_stray(s, int'($urandom_range(1, 3)));
      push_frame(s, int'($urandom_range(1, 40)), int'($urandom_range(0, 255)), 20);
      nfr++;
    end
    run_idle(20000, "t8");
    chk("t8_frames", 32'(fl_owner.size()), 32'(nfr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required end of test before it");
    $fatal(1, "watchdog expired");
  end

endmodule
